// File: rtl/des_pkg.sv
// Shared types and constants for the DES key schedule: FSM states, round
// geometry, the per-round rotate amounts and the round-to-slot mapping.
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int SUBKEY_W   = 48;
  localparam int HALF_W     = 28;
  localparam int KEYBUS_W   = NUM_ROUNDS * SUBKEY_W;

  localparam logic [4:0] LAST_ROUND = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Left-rotate amount of C and D for rounds 1..16 (entry 0 is round 1).
  localparam logic [1:0] SHIFT_SCHED [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt mode stores round n in slot 17-n so the core always starts at slot 1.
  function automatic logic [4:0] slot_idx(input logic [4:0] round, input logic dec);
    logic [4:0] slot;
    if (dec) begin
      slot = 5'd17 - round;
    end else begin
      slot = round;
    end
    return slot;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Request/result bundle between a key-schedule client and des_key_schedule.
interface des_key_schedule_if;
  import des_pkg::*;

  logic                start;
  logic [1:64]         key;
  logic                decrypt;
  logic                busy;
  logic                done;
  logic [1:KEYBUS_W]   round_keys;

  modport master (output start, key, decrypt, input busy, done, round_keys);
  modport slave  (input start, key, decrypt, output busy, done, round_keys);

endinterface

// File: rtl/des_pc1_permutation.sv
// DES Permuted Choice 1: drops the eight parity bits and reorders the key into C||D.
module des_pc1_permutation
  import des_pkg::*;
(
  input  logic [1:64]       key_i,
  output logic [1:2*HALF_W] cd_o
);

  localparam int PC1_TBL [2*HALF_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  for (genvar g = 0; g < 2*HALF_W; g++) begin : g_pc1
    assign cd_o[g+1] = key_i[PC1_TBL[g]];
  end

  // Parity bits are intentionally not part of the key material.
  logic unused_parity_s;
  assign unused_parity_s = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                             key_i[40], key_i[48], key_i[56], key_i[64]};

endmodule

// File: rtl/des_pc2_permutation.sv
// DES Permuted Choice 2: compresses the rotated C||D (56 bits) into a 48-bit round key.
module des_pc2_permutation
  import des_pkg::*;
(
  input  logic [1:2*HALF_W] cd_i,
  output logic [1:SUBKEY_W] subkey_o
);

  localparam int PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
    assign subkey_o[g+1] = cd_i[PC2_TBL[g]];
  end

  // PC-2 discards these eight positions of C||D.
  logic unused_drop_s;
  assign unused_drop_s = ^{cd_i[9], cd_i[18], cd_i[22], cd_i[25],
                           cd_i[35], cd_i[38], cd_i[43], cd_i[54]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 48-bit round key per cycle into a 768-bit
// slot bus, in encrypt order or reversed for decrypt.
module des_key_schedule
  import des_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  des_key_schedule_if.slave ks
);

  state_e                state_q, state_d;
  logic [4:0]            round_q, round_d;
  logic [1:HALF_W]       c_q, c_d, d_q, d_d;
  logic                  mode_q, mode_d;
  logic [1:KEYBUS_W]     round_keys_q, round_keys_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [1:2*HALF_W]     pc1_s;
  logic [1:HALF_W]       c_rot_s, d_rot_s;
  logic [1:SUBKEY_W]     subkey_s;
  logic [3:0]            round_idx_s;
  logic [1:0]            shift_s;
  logic [4:0]            slot_s;
  logic                  wr_en_s;

  des_pc1_permutation u_pc1 (
    .key_i (ks.key),
    .cd_o  (pc1_s)
  );

  des_pc2_permutation u_pc2 (
    .cd_i     ({c_rot_s, d_rot_s}),
    .subkey_o (subkey_s)
  );

  // Round 16 maps to index 15 through the 4-bit wrap of 0 - 1.
  always_comb begin
    round_idx_s = round_q[3:0] - 4'd1;
    shift_s     = SHIFT_SCHED[round_idx_s];
    if (shift_s == 2'd2) begin
      c_rot_s = {c_q[3:HALF_W], c_q[1:2]};
      d_rot_s = {d_q[3:HALF_W], d_q[1:2]};
    end else begin
      c_rot_s = {c_q[2:HALF_W], c_q[1]};
      d_rot_s = {d_q[2:HALF_W], d_q[1]};
    end
    slot_s = slot_idx(round_q, mode_q);
  end

  // Next-state, C/D update and round counter.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    c_d     = c_q;
    d_d     = d_q;
    mode_d  = mode_q;
    wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ks.start) begin
          c_d     = pc1_s[1:HALF_W];
          d_d     = pc1_s[HALF_W+1:2*HALF_W];
          mode_d  = ks.decrypt;
          round_d = 5'd1;
          state_d = ST_GEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        wr_en_s = 1'b1;
        c_d     = c_rot_s;
        d_d     = d_rot_s;
        if (round_q == LAST_ROUND) begin
          round_d = 5'd0;
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 5'd1;
          state_d = ST_GEN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        round_d = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Slot write: only the addressed slot changes; the others hold their previous keys.
  always_comb begin
    round_keys_d = round_keys_q;
    for (int s = 1; s <= NUM_ROUNDS; s++) begin
      round_keys_d[(s-1)*SUBKEY_W+1 +: SUBKEY_W] =
        (wr_en_s && (slot_s == s[4:0])) ? subkey_s
                                        : round_keys_q[(s-1)*SUBKEY_W+1 +: SUBKEY_W];
    end
  end

  // State, key material and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_q      <= 5'd0;
      c_q          <= '0;
      d_q          <= '0;
      mode_q       <= 1'b0;
      round_keys_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      c_q          <= c_d;
      d_q          <= d_d;
      mode_q       <= mode_d;
      round_keys_q <= round_keys_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ks.busy       = busy_q;
  assign ks.done       = done_q;
  assign ks.round_keys = round_keys_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized self-checking bench for des_key_schedule against a bit-list DES
// key-schedule model.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  des_key_schedule_if kif ();

  des_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (kif)
  );

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int ROT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Key bit p (1 = MSB) of a 64-bit word is k[64-p]; slot 1 sits in the top 48 bits.
  function automatic logic [767:0] ref_bus(input logic [63:0] k, input logic dec);
    bit c[28];
    bit d[28];
    bit t;
    logic [47:0]  sk [16];
    logic [767:0] bus;
    int idx;
    for (int i = 0; i < 28; i++) begin
      c[i] = k[64 - PC1_T[i]];
      d[i] = k[64 - PC1_T[28 + i]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < ROT_T[r]; s++) begin
        t = c[0];
        for (int i = 0; i < 27; i++) c[i] = c[i+1];
        c[27] = t;
        t = d[0];
        for (int i = 0; i < 27; i++) d[i] = d[i+1];
        d[27] = t;
      end
      for (int j = 0; j < 48; j++) begin
        idx = PC2_T[j] - 1;
        sk[r][47-j] = (idx < 28) ? c[idx] : d[idx-28];
      end
    end
    bus = '0;
    for (int s = 0; s < 16; s++) bus[767-48*s -: 48] = dec ? sk[15-s] : sk[s];
    return bus;
  endfunction

  function automatic logic [767:0] reverse_slots(input logic [767:0] b);
    logic [767:0] r;
    for (int s = 0; s < 16; s++) r[767-48*s -: 48] = b[767-48*(15-s) -: 48];
    return r;
  endfunction

  // One run: start pulse, optional ignored start at cycle `inject`, wait for done.
  task automatic run_key(input logic [63:0] k, input logic dec, input int inject,
                         output logic [767:0] bus);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    kif.key = k; kif.decrypt = dec; kif.start = 1'b1;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        kif.start = 1'b0; kif.key = ~k; kif.decrypt = ~dec;
      end
      if (inject != 0 && cyc == inject) begin
        kif.start = 1'b1; kif.key = 64'h0; kif.decrypt = 1'b1;
      end
      if (inject != 0 && cyc == inject + 1) kif.start = 1'b0;
      if (kif.busy) busy_cnt++;
      if (kif.done) seen = 1'b1;
    end
    check("latency", 768'(cyc), 768'(17));
    check("busy_len", 768'(busy_cnt), 768'(17));
    bus = kif.round_keys;
    @(negedge clk);
    check("done_pulse", 768'(kif.done), 768'(0));
  endtask

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;

  logic [767:0] enc_bus, dec_bus, bus, saved, all_ones;
  logic [63:0]  rk, cur_k;
  logic         rd, cur_d;
  int           cyc, since, last_done, runs;

  initial begin
    all_ones = '1;
    rst_n = 1'b0;
    kif.start = 1'b0; kif.key = 64'h0; kif.decrypt = 1'b0;
    #3;
    check("rst_keys", kif.round_keys, 768'(0));
    check("rst_busy", 768'(kif.busy), 768'(0));
    check("rst_done", 768'(kif.done), 768'(0));
    @(negedge clk); rst_n = 1'b1;

    // Encrypt order against known DES subkeys.
    run_key(GOLD_KEY, 1'b0, 0, enc_bus);
    check("enc_slot1", 768'(enc_bus[767 -: 48]), 768'(48'h1B02EFFC7072));
    check("enc_slot2", 768'(enc_bus[719 -: 48]), 768'(48'h79AED9DBC9E5));
    check("enc_slot16", 768'(enc_bus[47:0]), 768'(48'hCB3D8B0E17F5));
    check("enc_model", enc_bus, ref_bus(GOLD_KEY, 1'b0));

    run_key(GOLD_KEY, 1'b1, 0, dec_bus);
    check("dec_slot1", 768'(dec_bus[767 -: 48]), 768'(48'hCB3D8B0E17F5));
    check("dec_slot16", 768'(dec_bus[47:0]), 768'(48'h1B02EFFC7072));
    check("dec_reversed", dec_bus, reverse_slots(enc_bus));

    // Weak keys; parity bits must not matter.
    run_key(64'h0101010101010101, 1'b0, 0, bus);
    check("weak_zero", bus, 768'(0));
    run_key(64'hFEFEFEFEFEFEFEFE, 1'b1, 0, bus);
    check("weak_ones", bus, all_ones);
    run_key(64'h0000000000000000, 1'b0, 0, bus);
    check("parity_zero", bus, 768'(0));

    // Start during generation is ignored; result holds while idle.
    run_key(GOLD_KEY, 1'b0, 5, bus);
    check("ignored_start", bus, enc_bus);
    saved = kif.round_keys;
    repeat (10) begin
      @(negedge clk);
      check("idle_hold", kif.round_keys, saved);
    end

    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      run_key(rk, rd, 0, bus);
      check("rand_model", bus, ref_bus(rk, rd));
    end

    // Asynchronous reset mid-run, between clock edges.
    @(negedge clk); kif.key = GOLD_KEY; kif.decrypt = 1'b0; kif.start = 1'b1;
    @(negedge clk); kif.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_keys", kif.round_keys, 768'(0));
    check("arst_busy", 768'(kif.busy), 768'(0));
    check("arst_done", 768'(kif.done), 768'(0));
    @(negedge clk); rst_n = 1'b1;
    rk = {$urandom, $urandom};
    run_key(rk, 1'b1, 0, bus);
    check("post_rst_model", bus, ref_bus(rk, 1'b1));

    // Back-to-back: start held high, new key per run, junk key mid-run.
    @(negedge clk);
    cur_k = {$urandom, $urandom}; cur_d = 1'($urandom_range(0, 1));
    kif.key = cur_k; kif.decrypt = cur_d; kif.start = 1'b1;
    cyc = 0; since = 0; last_done = -1; runs = 0;
    while (runs < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++; since++;
      if (since == 3) begin
        kif.key = {$urandom, $urandom}; kif.decrypt = ~cur_d;
      end
      if (kif.done) begin
        check("b2b_model", kif.round_keys, ref_bus(cur_k, cur_d));
        if (last_done >= 0) check("b2b_gap", 768'(cyc - last_done), 768'(18));
        last_done = cyc;
        runs++;
        cur_k = {$urandom, $urandom}; cur_d = 1'($urandom_range(0, 1));
        kif.key = cur_k; kif.decrypt = cur_d;
        since = 0;
      end
    end
    kif.start = 1'b0;
    check("b2b_runs", 768'(runs), 768'(4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES key schedule that feeds the encryption/decryption core's 768-bit round-key bus. It accepts a 64-bit key with parity bits and applies PC-1. It then generates one 48-bit round key per cycle through the C/D rotations and PC-2, placing each key in its slot. In decrypt mode the slots are filled in reverse order, so the downstream core always consumes slot 1 first.

Parameters:
NUM_ROUNDS, 16, number of round keys generated; fixed by DES, not meant to be overridden.
SUBKEY_W, 48, width of one round key; round_keys width = NUM_ROUNDS*SUBKEY_W = 768.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active low
start  input  1  request; sampled only in IDLE; key and decrypt are valid in the same cycle
key  input  [1:64]  DES key; bits 8,16,...,64 are parity and are ignored by PC-1
decrypt  input  1  0 = encrypt order (K1 in slot 1), 1 = decrypt order (K16 in slot 1)
busy  output  1  high in GEN and DONE
done  output  1  one-cycle pulse; round_keys valid and complete
round_keys  output  [1:768]  slot s occupies bits [48*(s-1)+1 : 48*s]; slot 1 = bits [1:48]

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, round counter = 0, C/D registers = 0, round_keys = 0, done = 0, busy = 0.
- Reset asserted mid-operation aborts generation immediately; no partial keys survive.
- State register states: IDLE, GEN, DONE.
- Outputs done and busy are decoded from the registered state and are glitch-free.
- IDLE:
  - On an edge with start = 1: C,D <= PC1(key) (28+28 bits); latch decrypt into mode_r; counter <= 1; go to GEN.
  - round_keys is not cleared on start; it keeps its old value until overwritten slot by slot.
- GEN, one round per edge:
  - Rotate C and D left by shift(counter): 1 for rounds 1, 2, 9, 16; 2 for all other rounds.
  - Kn = PC2({C_rot, D_rot}), with n = counter.
  - Write Kn into slot n if mode_r = 0, or slot 17-n if mode_r = 1.
  - C,D <= rotated values.
  - counter increments; when counter = 16 the write happens and the next state is DONE.
  - Total shift over 16 rounds = 28, so C and D return to their PC-1 values.
- DONE: done = 1 for exactly one cycle, busy = 1, then return to IDLE.
- Latency: start is sampled at edge E0 and keys are written at edges E1..E16. The state is DONE after E16, so done is high in the cycle following E16, 17 cycles after start.
- After DONE, round_keys holds its value until the next accepted start, so the consumer may sample it any time after done.
- start while busy: ignored; key and decrypt changes during GEN have no effect because mode_r and C/D are private copies.
- start held high continuously: a new run begins every 18 cycles (IDLE accepts it on the cycle after DONE).
- Counter is 5 bits to avoid wrap ambiguity; it never exceeds 16.

Decomposition:
- Package des_pkg:
  - state encoding localparams (IDLE/GEN/DONE);
  - NUM_ROUNDS and SUBKEY_W;
  - 16-entry shift-schedule constant (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1);
  - slot-index helper function.
- Sub-modules: two combinational primitives placed alongside the existing IP primitives:
  - des_pc1_permutation (64 -> 56);
  - des_pc2_permutation (56 -> 48).
  - The FSM, C/D registers and slot write logic stay in des_key_schedule.

Test Plan:
- Encrypt order: key = 133457799BBCDFF1, decrypt = 0, start pulse -> done 17 cycles later. Slot 1 = 1B02EFFC7072, slot 2 = 79AED9DBC9E5, slot 16 = CB3D8B0E17F5, busy high for 17 cycles.
- Decrypt order: same key, decrypt = 1 -> slot 1 = CB3D8B0E17F5, slot 16 = 1B02EFFC7072. Full bus equals the encrypt bus with slots reversed.
- Weak keys: key = 0101010101010101 -> round_keys all 0. Key = FEFEFEFEFEFEFEFE -> round_keys all 1s. A parity-flipped variant 0000000000000000 gives the identical all-zero result.
- Protocol: start with key 133457799BBCDFF1, then at cycle 5 assert start with key 0 and decrypt = 1 -> ignored, and the result matches the first scenario. round_keys is unchanged for 10 idle cycles after done.
- Reset mid-run: start, then pull rst_n low asynchronously (between edges) at cycle 8 -> round_keys, busy and done go to 0 immediately. After release a fresh start completes correctly in 17 cycles.
- Back-to-back: start held high, keys changed each run -> done pulses exactly 18 cycles apart, and each run's bus matches the golden model for the key sampled at its start.
